// File: rtl/reg_pkg.sv
// Shared constants and the writeback request type for the register writeback stage.
package reg_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned ADDR_WIDTH       = 4;
  localparam int unsigned NUM_REGS         = 2 ** ADDR_WIDTH;
  localparam int unsigned WB_PAYLOAD_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned FIFO_CNT_WIDTH   = 4;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Memory (load) result channel: valid/ready handshake carrying destination and data.
interface reg_writeback_unit_if;
  import reg_pkg::*;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_dest;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (output mem_valid, output mem_dest, output mem_data, input mem_ready);
  modport slave  (input mem_valid, input mem_dest, input mem_data, output mem_ready);

endinterface

// File: rtl/reg_writeback_unit_wb_result_fifo.sv
// Synchronous FIFO for buffered memory results; push/pop are ignored when full/empty.
module wb_result_fifo #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned WIDTH     = 36,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push_ok, pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full     = (count_q == CNT_WIDTH'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage: ALU-priority arbiter over ALU and buffered load results, plus load scoreboard.
// Define REG_WB_BYPASS_OUT_EN for combinational (0-cycle) register-file write outputs.
module reg_writeback_unit
  import reg_pkg::*;
#(
  parameter int unsigned MEM_FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [ADDR_WIDTH-1:0]     alu_dest,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  reg_writeback_unit_if.slave       mem_if,
  input  logic                      issue_valid,
  input  logic [ADDR_WIDTH-1:0]     issue_dest,
  output logic                      rf_write_enable,
  output logic [ADDR_WIDTH-1:0]     rf_dest,
  output logic [DATA_WIDTH-1:0]     rf_data,
  output logic [NUM_REGS-1:0]       busy_mask,
  output logic [FIFO_CNT_WIDTH-1:0] fifo_count
);

  logic [WB_PAYLOAD_WIDTH-1:0] push_payload, head_payload;
  logic [ADDR_WIDTH-1:0]       head_dest;
  logic                        fifo_full, fifo_empty, pop;
  wb_req_t                     sel;
  logic [NUM_REGS-1:0]         busy_q, busy_d;

  assign push_payload = {mem_if.mem_dest, mem_if.mem_data};
  assign head_dest    = head_payload[WB_PAYLOAD_WIDTH-1 -: ADDR_WIDTH];
  assign mem_if.mem_ready = !fifo_full;

  wb_result_fifo #(
    .DEPTH     (MEM_FIFO_DEPTH),
    .WIDTH     (WB_PAYLOAD_WIDTH),
    .CNT_WIDTH (FIFO_CNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_if.mem_valid),
    .push_data (push_payload),
    .pop       (pop),
    .pop_data  (head_payload),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ALU has strict priority; loads drain only in ALU-idle cycles.
  assign pop = !alu_valid && !fifo_empty;

  always_comb begin
    sel = '0;
    if (alu_valid) begin
      sel = '{valid: 1'b1, dest: alu_dest, data: alu_data};
    end else if (pop) begin
      sel = '{valid: 1'b1, dest: head_dest, data: head_payload[DATA_WIDTH-1:0]};
    end
  end

  // Set after clear so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_dest] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

`ifdef REG_WB_BYPASS_OUT_EN
  logic [ADDR_WIDTH-1:0] last_dest_q;
  logic [DATA_WIDTH-1:0] last_data_q;
  logic                  wr;

  assign wr = sel.valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dest_q <= '0;
      last_data_q <= '0;
    end else if (sel.valid) begin
      last_dest_q <= sel.dest;
      last_data_q <= sel.data;
    end
  end

  assign rf_write_enable = wr;
  assign rf_dest         = wr ? sel.dest : last_dest_q;
  assign rf_data         = wr ? sel.data : last_data_q;
`else
  wb_req_t wb_q;

  // Dest/data hold their last written values while write_enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (sel.valid) begin
      wb_q <= sel;
    end else begin
      wb_q.valid <= 1'b0;
    end
  end

  assign rf_write_enable = wb_q.valid;
  assign rf_dest         = wb_q.dest;
  assign rf_data         = wb_q.data;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a queue-based reference model checked every cycle.
module tb_reg_writeback_unit;
  import reg_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  alu_valid, issue_valid;
  logic [ADDR_WIDTH-1:0] alu_dest, issue_dest;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  rf_write_enable;
  logic [ADDR_WIDTH-1:0] rf_dest;
  logic [DATA_WIDTH-1:0] rf_data;
  logic [NUM_REGS-1:0]   busy_mask;
  logic [3:0]            fifo_count;

  reg_writeback_unit_if mem_if();

  reg_writeback_unit #(
    .MEM_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_dest        (alu_dest),
    .alu_data        (alu_data),
    .mem_if          (mem_if),
    .issue_valid     (issue_valid),
    .issue_dest      (issue_dest),
    .rf_write_enable (rf_write_enable),
    .rf_dest         (rf_dest),
    .rf_data         (rf_data),
    .busy_mask       (busy_mask),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t                  mq[$];
  logic [NUM_REGS-1:0]   m_busy;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_dest;
  logic [DATA_WIDTH-1:0] m_data;
  bit                    live = 1'b0;
  bit                    log_en = 1'b0;
  logic [DATA_WIDTH-1:0] wlog[$];
  int                    checks = 0;
  int                    errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: compare outputs against state after the previous edge, then advance to the next edge.
  always @(negedge clk) begin
    logic                  pop, push, sel_v;
    logic [ADDR_WIDTH-1:0] sel_d;
    logic [DATA_WIDTH-1:0] sel_dt;
    pop    = !alu_valid && (mq.size() > 0);
    sel_v  = alu_valid || pop;
    sel_d  = alu_valid ? alu_dest : (pop ? mq[0].dest : '0);
    sel_dt = alu_valid ? alu_data : (pop ? mq[0].data : '0);
    if (live) begin
      check("busy_mask", 32'(busy_mask), 32'(m_busy));
      check("fifo_count", 32'(fifo_count), mq.size());
      check("mem_ready", 32'(mem_if.mem_ready), 32'(mq.size() != DEPTH));
`ifdef REG_WB_BYPASS_OUT_EN
      check("rf_write_enable", 32'(rf_write_enable), 32'(sel_v && !rst));
      if (!rst) begin
        check("rf_dest", 32'(rf_dest), 32'(sel_v ? sel_d : m_dest));
        check("rf_data", rf_data, sel_v ? sel_dt : m_data);
      end
`else
      check("rf_write_enable", 32'(rf_write_enable), 32'(m_we));
      check("rf_dest", 32'(rf_dest), 32'(m_dest));
      check("rf_data", rf_data, m_data);
`endif
    end
    if (log_en && rf_write_enable) wlog.push_back(rf_data);
    if (live && !rst && issue_valid && m_busy[issue_dest] &&
        !(pop && mq[0].dest == issue_dest)) begin
      errors++;
      $display("FAIL issue_to_busy: register %0d issued while busy", issue_dest);
    end
    if (rst) begin
      mq.delete();
      m_busy = '0;
      m_we   = 1'b0;
      m_dest = '0;
      m_data = '0;
      live   = 1'b1;
    end else begin
      push = mem_if.mem_valid && (mq.size() != DEPTH);
      if (pop) begin
        m_busy[mq[0].dest] = 1'b0;
        void'(mq.pop_front());
      end
      if (push) mq.push_back({mem_if.mem_dest, mem_if.mem_data});
      if (issue_valid) m_busy[issue_dest] = 1'b1;
      m_we = sel_v;
      if (sel_v) begin
        m_dest = sel_d;
        m_data = sel_dt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid        = 1'b0;
    alu_dest         = '0;
    alu_data         = '0;
    issue_valid      = 1'b0;
    issue_dest       = '0;
    mem_if.mem_valid = 1'b0;
    mem_if.mem_dest  = '0;
    mem_if.mem_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   m;
    logic hs;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Fill FIFO with two loads behind ALU traffic, then reset mid-operation.
    alu_valid = 1'b1; issue_valid = 1'b1; issue_dest = 4'd1;
    mem_if.mem_valid = 1'b1; mem_if.mem_dest = 4'd1; mem_if.mem_data = 32'h11;
    tick();
    issue_dest = 4'd4; mem_if.mem_dest = 4'd4; mem_if.mem_data = 32'h44;
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    check("pre_rst_busy", 32'(busy_mask), 32'h0012);
    idle();
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(busy_mask), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_ready", 32'(mem_if.mem_ready), 32'h1);
    check("rst_we0", 32'(rf_write_enable), 32'h0);
    rst = 1'b0;
    tick();
    check("rst_we1", 32'(rf_write_enable), 32'h0);

    // Single ALU write.
    alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle();
`ifndef REG_WB_BYPASS_OUT_EN
    check("alu_we", 32'(rf_write_enable), 32'h1);
    check("alu_dest", 32'(rf_dest), 32'd5);
    check("alu_data", rf_data, 32'hDEADBEEF);
`endif
    tick();
    check("alu_we_off", 32'(rf_write_enable), 32'h0);
    check("alu_dest_hold", 32'(rf_dest), 32'd5);

    // Issue r3, load returns four cycles later.
    issue_valid = 1'b1; issue_dest = 4'd3;
    tick();
    idle();
    check("issue_busy3", 32'(busy_mask), 32'h0008);
    tick(); tick(); tick();
    mem_if.mem_valid = 1'b1; mem_if.mem_dest = 4'd3; mem_if.mem_data = 32'h1234;
    tick();
    idle();
    check("ld_count1", 32'(fifo_count), 32'd1);
    check("ld_busy_held", 32'(busy_mask), 32'h0008);
    tick();
`ifndef REG_WB_BYPASS_OUT_EN
    check("ld_we", 32'(rf_write_enable), 32'h1);
    check("ld_dest", 32'(rf_dest), 32'd3);
    check("ld_data", rf_data, 32'h1234);
`endif
    check("ld_busy_clr", 32'(busy_mask), 32'h0);

    // Sustained ALU traffic starves the FIFO while three loads are offered.
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_dest = 4'(8 + i);
      tick();
    end
    issue_valid = 1'b0;
    m = 0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'hA000 + i;
      mem_if.mem_valid = (m < 3);
      mem_if.mem_dest  = 4'(8 + m);
      mem_if.mem_data  = 32'hB000 + m;
      hs = mem_if.mem_valid && mem_if.mem_ready;
      tick();
      if (hs) m++;
    end
    idle();
    check("starve_accepted", m, 32'd2);
    check("starve_count", 32'(fifo_count), 32'd2);
    check("starve_ready", 32'(mem_if.mem_ready), 32'h0);
    tick();
`ifndef REG_WB_BYPASS_OUT_EN
    check("drain0_dest", 32'(rf_dest), 32'd8);
    check("drain0_data", rf_data, 32'hB000);
`endif
    tick();
`ifndef REG_WB_BYPASS_OUT_EN
    check("drain1_dest", 32'(rf_dest), 32'd9);
    check("drain1_data", rf_data, 32'hB001);
`endif
    tick();
    check("drain_busy", 32'(busy_mask), 32'h0400);
    mem_if.mem_valid = 1'b1; mem_if.mem_dest = 4'd10; mem_if.mem_data = 32'hB002;
    tick();
    idle();
    tick(); tick();

    // Same-cycle issue and retirement of r7: set wins.
    issue_valid = 1'b1; issue_dest = 4'd7;
    tick();
    issue_valid = 1'b0;
    mem_if.mem_valid = 1'b1; mem_if.mem_dest = 4'd7; mem_if.mem_data = 32'h77;
    tick();
    mem_if.mem_valid = 1'b0;
    issue_valid = 1'b1; issue_dest = 4'd7;
    tick();
    idle();
    check("setwins_busy", 32'(busy_mask), 32'h0080);
`ifndef REG_WB_BYPASS_OUT_EN
    check("setwins_data", rf_data, 32'h77);
`endif
    mem_if.mem_valid = 1'b1; mem_if.mem_dest = 4'd7; mem_if.mem_data = 32'h78;
    tick();
    idle();
    tick(); tick();
    check("setwins_final", 32'(busy_mask), 32'h0);

    // Steady push+pop at occupancy 1; writes must follow arrival order.
    log_en = 1'b1;
    mem_if.mem_valid = 1'b1; mem_if.mem_dest = 4'd0; mem_if.mem_data = 32'h200;
    tick();
    for (int i = 1; i <= 10; i++) begin
      mem_if.mem_dest = 4'(i); mem_if.mem_data = 32'h200 + i;
      tick();
      check("steady_count", 32'(fifo_count), 32'd1);
    end
    idle();
    tick(); tick(); tick();
    log_en = 1'b0;
    check("order_len", wlog.size(), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < wlog.size()) check("order_data", wlog[i], 32'h200 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
